// File: rtl/memoria_pkg.sv
// Shared sizing for the 8x4 memoria block and the FIFO controller that drives it.
package memoria_pkg;

  localparam int MEM_DATA_W = 4;
  localparam int MEM_ADDR_W = 3;
  localparam int MEM_DEPTH  = 8;
  localparam int AF_THR_DEF = 6;
  localparam int AE_THR_DEF = 2;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_t;

endpackage

// File: rtl/memoria_fifo_ptr.sv
// Wrap-bit FIFO pointer: low ADDR_W bits address memory, MSB flips on each wrap.
module memoria_fifo_ptr
  import memoria_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_inc,
  output logic [ADDR_W:0] o_ptr
);

  logic [ADDR_W:0] r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/memoria_fifo_ctrl.sv
// FIFO controller for the memoria dual-port RAM: port A pushes, port B pops,
// with registered occupancy/flags and a two-stage read-valid pipeline.
module memoria_fifo_ctrl
  import memoria_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int AF_THR = AF_THR_DEF,
  parameter int AE_THR = AE_THR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] AddrA,
  output logic              rwA,
  output logic [DATA_W-1:0] DataInA,
  output logic [ADDR_W-1:0] AddrB,
  output logic              rwB,
  input  logic [DATA_W-1:0] DataOutB
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_THR);
  localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_THR);

  logic [ADDR_W:0]   w_wr_ptr;
  logic [ADDR_W:0]   w_rd_ptr;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_push_ok;
  logic              w_pop_ok;

  logic [ADDR_W:0]   r_cnt;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic              r_ovf;
  logic              r_udf;
  logic [ADDR_W-1:0] r_addr_a;
  logic [DATA_W-1:0] r_din_a;
  logic              r_rw_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic              r_pop_d1;
  logic              r_rd_valid;

  // A push into a full FIFO still goes through when a pop frees the slot at the same edge.
  assign w_push_ok = push & (~r_full | w_pop_ok);
  assign w_pop_ok  = pop & ~r_empty;

  memoria_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_push_ok),
    .o_ptr (w_wr_ptr)
  );

  memoria_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_pop_ok),
    .o_ptr (w_rd_ptr)
  );

  // Occupancy follows from the next pointer pair; the wrap bit makes 0 and DEPTH distinct.
  assign w_cnt_nxt = (w_wr_ptr + {{ADDR_W{1'b0}}, w_push_ok})
                   - (w_rd_ptr + {{ADDR_W{1'b0}}, w_pop_ok});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_af       <= 1'b0;
      r_ae       <= 1'b1;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_addr_a   <= '0;
      r_din_a    <= '0;
      r_rw_a     <= 1'b0;
      r_addr_b   <= '0;
      r_pop_d1   <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == LP_DEPTH);
      r_empty <= (w_cnt_nxt == '0);
      r_af    <= (w_cnt_nxt >= LP_AF);
      r_ae    <= (w_cnt_nxt <= LP_AE);
      if (push & ~w_push_ok) r_ovf <= 1'b1;
      if (pop & r_empty)     r_udf <= 1'b1;
      r_rw_a <= w_push_ok;
      if (w_push_ok) begin
        r_addr_a <= w_wr_ptr[ADDR_W-1:0];
        r_din_a  <= wr_data;
      end
      if (w_pop_ok) r_addr_b <= w_rd_ptr[ADDR_W-1:0];
      // Stage 1 covers the memory's address sample, stage 2 its registered output.
      r_pop_d1   <= w_pop_ok;
      r_rd_valid <= r_pop_d1;
    end
  end

  assign fifo_cnt     = r_cnt;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign AddrA        = r_addr_a;
  assign DataInA      = r_din_a;
  assign rwA          = r_rw_a;
  assign AddrB        = r_addr_b;
  assign rwB          = 1'b0;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_valid ? DataOutB : '0;

endmodule
